// File: rtl/fu_pkg.sv
// Shared definitions for the issue scoreboard: functional-unit codes,
// write-back reservation slot layout and default unit latencies.
package fu_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned ALU_LAT_DEF = 3;
    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 34;

    typedef enum logic [1:0] {
        FU_ALU  = 2'b00,
        FU_MUL  = 2'b01,
        FU_DIV  = 2'b10,
        FU_NONE = 2'b11
    } fu_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        fu_e              src;
    } rsr_slot_t;

endpackage

// File: rtl/wb_slot_ring.sv
// Result shift register: one slot per future write-back cycle, shifting
// toward slot[0] every edge, with a load port and an occupancy probe.
module wb_slot_ring
    import fu_pkg::*;
#(
    parameter int unsigned DEPTH = DIV_LAT_DEF,
    localparam int unsigned IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [REG_W-1:0] load_rd,
    input  logic [1:0]       load_src,
    input  logic [IDX_W-1:0] occ_idx,
    output logic             occ_valid_c,
    output logic             head_valid_c,
    output logic [REG_W-1:0] head_rd_c,
    output logic [1:0]       head_src_c
);

    rsr_slot_t slots [DEPTH];

    // Shift down one slot per edge; the load lands after the shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                slots[i] <= slots[i+1];
            end
            slots[DEPTH-1] <= '0;
            if (load_en) begin
                slots[load_idx] <= '{valid: 1'b1, rd: load_rd, src: fu_e'(load_src)};
            end
        end
    end

    // slot[DEPTH] does not exist: it is always empty after the shift
    always_comb begin
        occ_valid_c = 1'b0;
        if (occ_idx < IDX_W'(DEPTH)) begin
            occ_valid_c = slots[occ_idx].valid;
        end
    end

    assign head_valid_c = slots[0].valid;
    assign head_rd_c    = slots[0].rd;
    assign head_src_c   = slots[0].src;

endmodule

// File: rtl/fu_issue_scoreboard.sv
// Issue-stage scoreboard: tracks pending destination registers, stalls ID on
// RAW/WAW/port/divider hazards and schedules the single register-file write port.
module fu_issue_scoreboard
    import fu_pkg::*;
#(
    parameter int unsigned ALU_LAT = ALU_LAT_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic       flush_ID,
    input  logic [1:0] fu_ID,
    input  logic [4:0] rd_ID,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       rs1use_ID,
    input  logic       rs2use_ID,
    output logic       stall_ID,
    output logic       mul_start,
    output logic       div_start,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic [1:0] wb_src,
    output logic       fwd_wb_rs1,
    output logic       fwd_wb_rs2
);

    localparam int unsigned IDX_W = $clog2(DIV_LAT + 1);
    localparam int unsigned CNT_W = $clog2(DIV_LAT);

    fu_e                  fu;
    logic [IDX_W-1:0]     lat;
    logic                 writes;
    logic                 accept;
    logic                 occ_valid;
    logic [NUM_REGS-1:0]  pend;
    logic [NUM_REGS-1:0]  pend_nxt;
    logic [NUM_REGS-1:0]  retire_mask;
    logic [NUM_REGS-1:0]  pend_live;
    logic [CNT_W-1:0]     div_cnt;
    logic                 haz_raw1, haz_raw2, haz_waw, haz_port, haz_div;

    assign fu     = fu_e'(fu_ID);
    assign writes = (fu != FU_NONE) && (rd_ID != '0);

    // Write-back latency of the op currently in ID
    always_comb begin
        case (fu)
            FU_MUL:  lat = IDX_W'(MUL_LAT);
            FU_DIV:  lat = IDX_W'(DIV_LAT);
            default: lat = IDX_W'(ALU_LAT);
        endcase
    end

    wb_slot_ring #(
        .DEPTH (DIV_LAT)
    ) u_ring (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (accept && writes),
        .load_idx     (lat - IDX_W'(1)),
        .load_rd      (rd_ID),
        .load_src     (fu_ID),
        .occ_idx      (lat),
        .occ_valid_c  (occ_valid),
        .head_valid_c (wb_valid),
        .head_rd_c    (wb_rd),
        .head_src_c   (wb_src)
    );

    assign retire_mask = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
    assign pend_live   = pend & ~retire_mask;

    // A source retiring this cycle is served by the WB forward path, so RAW ignores it
    assign haz_raw1 = rs1use_ID && (rs1_ID != '0) && pend_live[rs1_ID];
    assign haz_raw2 = rs2use_ID && (rs2_ID != '0) && pend_live[rs2_ID];
    assign haz_waw  = writes && pend[rd_ID];
    assign haz_port = writes && occ_valid;
    assign haz_div  = (fu == FU_DIV) && (div_cnt != '0);

    assign stall_ID = issue_valid && !flush_ID &&
                      (haz_raw1 || haz_raw2 || haz_waw || haz_port || haz_div);
    assign accept   = rst_n && issue_valid && !flush_ID && !stall_ID;

    assign mul_start  = accept && (fu == FU_MUL);
    assign div_start  = accept && (fu == FU_DIV);
    assign fwd_wb_rs1 = rs1use_ID && wb_valid && (rs1_ID != '0) && (wb_rd == rs1_ID);
    assign fwd_wb_rs2 = rs2use_ID && wb_valid && (rs2_ID != '0) && (wb_rd == rs2_ID);

    // Set on accept wins over the retiring clear of the same register
    always_comb begin
        pend_nxt = pend & ~retire_mask;
        if (accept && writes) begin
            pend_nxt[rd_ID] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Divider occupancy: blocks the next DIV until the current one drains
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (accept && (fu == FU_DIV)) begin
            div_cnt <= CNT_W'(DIV_LAT - 1);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fu_issue_scoreboard.sv
// Directed bench for fu_issue_scoreboard: reset, RAW, port conflict, divider
// structural hazard, WAW/x0, flush and mid-operation reset scenarios.
module tb_fu_issue_scoreboard;
    import fu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic       flush_ID;
    logic [1:0] fu_ID;
    logic [4:0] rd_ID, rs1_ID, rs2_ID;
    logic       rs1use_ID, rs2use_ID;
    logic       stall_ID, mul_start, div_start, wb_valid;
    logic [4:0] wb_rd;
    logic [1:0] wb_src;
    logic       fwd_wb_rs1, fwd_wb_rs2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fu_issue_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .flush_ID    (flush_ID),
        .fu_ID       (fu_ID),
        .rd_ID       (rd_ID),
        .rs1_ID      (rs1_ID),
        .rs2_ID      (rs2_ID),
        .rs1use_ID   (rs1use_ID),
        .rs2use_ID   (rs2use_ID),
        .stall_ID    (stall_ID),
        .mul_start   (mul_start),
        .div_start   (div_start),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_src      (wb_src),
        .fwd_wb_rs1  (fwd_wb_rs1),
        .fwd_wb_rs2  (fwd_wb_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic [1:0] fu,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        issue_valid = v;
        flush_ID    = fl;
        fu_ID       = fu;
        rd_ID       = rd;
        rs1_ID      = rs1;
        rs2_ID      = rs2;
        rs1use_ID   = u1;
        rs2use_ID   = u2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, FU_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starting in the cycle after issue: expect n-1 quiet cycles then the write
    task automatic wait_wb(input int unsigned n, input logic [4:0] rd,
                           input logic [1:0] src, input string tag);
        for (int i = 1; i < int'(n); i++) begin
            @(negedge clk);
            check({tag, "_quiet"}, 32'(wb_valid), 32'd0);
            cyc();
        end
        @(negedge clk);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
        check({tag, "_wb_src"}, 32'(wb_src), 32'(src));
        cyc();
    endtask

    initial begin
        // Reset held for two edges with a MUL presented in ID
        rst_n = 1'b0;
        drive(1'b1, 1'b0, FU_MUL, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_stall", 32'(stall_ID), 32'd0);
        check("rst_fwd1", 32'(fwd_wb_rs1), 32'd0);
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, FU_ALU, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("alu_stall", 32'(stall_ID), 32'd0);
        check("alu_wb_idle", 32'(wb_valid), 32'd0);
        cyc();
        idle();
        wait_wb(3, 5'd5, FU_ALU, "alu");

        // RAW on x7 behind a MUL, released with WB forwarding
        drive(1'b1, 1'b0, FU_MUL, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("raw_mul_start", 32'(mul_start), 32'd1);
        check("raw_mul_stall", 32'(stall_ID), 32'd0);
        cyc();
        drive(1'b1, 1'b0, FU_ALU, 5'd10, 5'd7, 5'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("raw_stall", 32'(stall_ID), 32'd1);
            check("raw_fwd1_early", 32'(fwd_wb_rs1), 32'd0);
            cyc();
        end
        @(negedge clk);
        check("raw_release", 32'(stall_ID), 32'd0);
        check("raw_fwd1", 32'(fwd_wb_rs1), 32'd1);
        check("raw_fwd2_x0", 32'(fwd_wb_rs2), 32'd0);
        check("raw_wb_rd", 32'(wb_rd), 32'd7);
        check("raw_wb_src", 32'(wb_src), 32'(FU_MUL));
        cyc();
        idle();
        wait_wb(3, 5'd10, FU_ALU, "raw_add");

        // Port conflict: MUL x3 then ALU x4 both aim at cycle 4
        drive(1'b1, 1'b0, FU_MUL, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("port_mul_stall", 32'(stall_ID), 32'd0);
        cyc();
        drive(1'b1, 1'b0, FU_ALU, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("port_alu_stall", 32'(stall_ID), 32'd1);
        cyc();
        @(negedge clk);
        check("port_alu_accept", 32'(stall_ID), 32'd0);
        cyc();
        idle();
        @(negedge clk);
        check("port_c3_quiet", 32'(wb_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("port_c4_valid", 32'(wb_valid), 32'd1);
        check("port_c4_rd", 32'(wb_rd), 32'd3);
        check("port_c4_src", 32'(wb_src), 32'(FU_MUL));
        cyc();
        @(negedge clk);
        check("port_c5_valid", 32'(wb_valid), 32'd1);
        check("port_c5_rd", 32'(wb_rd), 32'd4);
        check("port_c5_src", 32'(wb_src), 32'(FU_ALU));
        cyc();
        @(negedge clk);
        check("port_c6_quiet", 32'(wb_valid), 32'd0);
        cyc();

        // Divider structural hazard: second DIV waits for the first to drain
        drive(1'b1, 1'b0, FU_DIV, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("div_start_first", 32'(div_start), 32'd1);
        check("div_stall_first", 32'(stall_ID), 32'd0);
        cyc();
        drive(1'b1, 1'b0, FU_DIV, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            check("div_struct_stall", 32'(stall_ID), 32'd1);
            check("div_struct_nostart", 32'(div_start), 32'd0);
            cyc();
        end
        @(negedge clk);
        check("div_c34_stall", 32'(stall_ID), 32'd0);
        check("div_c34_start", 32'(div_start), 32'd1);
        check("div_c34_wb_valid", 32'(wb_valid), 32'd1);
        check("div_c34_wb_rd", 32'(wb_rd), 32'd2);
        check("div_c34_wb_src", 32'(wb_src), 32'(FU_DIV));
        cyc();
        idle();
        wait_wb(34, 5'd9, FU_DIV, "div2");

        // WAW on x8: stall lasts through the MUL retire cycle
        drive(1'b1, 1'b0, FU_MUL, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("waw_mul_stall", 32'(stall_ID), 32'd0);
        cyc();
        drive(1'b1, 1'b0, FU_ALU, 5'd8, 5'd0, 5'd8, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("waw_stall", 32'(stall_ID), 32'd1);
            cyc();
        end
        @(negedge clk);
        check("waw_retire_stall", 32'(stall_ID), 32'd1);
        check("waw_retire_rd", 32'(wb_rd), 32'd8);
        check("waw_fwd2_stalled", 32'(fwd_wb_rs2), 32'd1);
        cyc();
        @(negedge clk);
        check("waw_release", 32'(stall_ID), 32'd0);
        cyc();
        idle();
        wait_wb(3, 5'd8, FU_ALU, "waw_alu");

        // x0 destination/source: no reservation, no port conflict, no stall
        drive(1'b1, 1'b0, FU_MUL, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("x0_mul_stall", 32'(stall_ID), 32'd0);
        cyc();
        drive(1'b1, 1'b0, FU_ALU, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("x0_alu_stall", 32'(stall_ID), 32'd0);
        cyc();
        idle();
        wait_wb(3, 5'd13, FU_MUL, "x0_mul");
        @(negedge clk);
        check("x0_no_wb", 32'(wb_valid), 32'd0);
        cyc();

        // Flushed DIV leaves no trace
        drive(1'b1, 1'b1, FU_DIV, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("flush_div_start", 32'(div_start), 32'd0);
        check("flush_stall", 32'(stall_ID), 32'd0);
        cyc();
        drive(1'b1, 1'b0, FU_ALU, 5'd15, 5'd6, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("flush_raw_stall", 32'(stall_ID), 32'd0);
        cyc();
        drive(1'b1, 1'b0, FU_DIV, 5'd16, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("flush_div2_stall", 32'(stall_ID), 32'd0);
        check("flush_div2_start", 32'(div_start), 32'd1);
        cyc();
        idle();
        @(negedge clk);
        check("flush_c3_quiet", 32'(wb_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("flush_c4_valid", 32'(wb_valid), 32'd1);
        check("flush_c4_rd", 32'(wb_rd), 32'd15);
        cyc();

        // Mid-operation reset drops the in-flight DIV x16 and the divider count
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, FU_DIV, 5'd17, 5'd16, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("rstmid_stall", 32'(stall_ID), 32'd0);
        check("rstmid_div_start", 32'(div_start), 32'd1);
        cyc();
        idle();
        wait_wb(34, 5'd17, FU_DIV, "rstmid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fu_issue_scoreboard.md
# fu_issue_scoreboard

Issue-stage scoreboard and write-back scheduler for the pipelined RISC-V core once multi-cycle MUL/DIV units are attached. It tracks registers with outstanding writes, stalls ID on RAW/WAW/structural hazards, and reserves the single register-file write port with a result shift register, so ALU, MUL and DIV results never collide. It sits beside the hazard detection unit, and its `stall_ID` is ORed into the existing ID stall.

## Interface
Parameters:
- `ALU_LAT`, 3: cycles from ID accept to write-back for ALU/load ops.
- `MUL_LAT`, 4: pipelined multiplier latency.
- `DIV_LAT`, 34: iterative divider latency. Legal range: 1 ≤ ALU_LAT < MUL_LAT ≤ DIV_LAT ≤ 64.

Ports:
- `clk`  in  1  — clock; all state updates on rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `issue_valid`  in  1  — ID holds a valid instruction.
- `flush_ID`  in  1  — ID instruction is squashed; never accepted.
- `fu_ID`  in  2  — 00 ALU/load, 01 MUL, 10 DIV, 11 no-write (store/branch).
- `rd_ID`, `rs1_ID`, `rs2_ID`  in  5 each  — register indices.
- `rs1use_ID`, `rs2use_ID`  in  1 each  — source is read.
- `stall_ID`  out  1  — hold IF/ID; instruction not accepted.
- `mul_start`, `div_start`  out  1 each  — one-cycle start pulse to the unit.
- `wb_valid`  out  1  — write port is owned this cycle.
- `wb_rd`  out  5  — destination register being written.
- `wb_src`  out  2  — fu code of the writer; steers the WB mux.
- `fwd_wb_rs1`, `fwd_wb_rs2`  out  1 each  — take the source from the WB bus.

## Operation
- Accept = `issue_valid & ~flush_ID & ~stall_ID`. Latency L is ALU_LAT, MUL_LAT or DIV_LAT, selected by `fu_ID`. An op writes only if fu≠11 and rd≠0.
- Result shift register (RSR): DIV_LAT slots, each holding {valid, rd, src}. Every edge, slot[i] ← slot[i+1], and the top slot is cleared. On an accepted writing op, slot[L-1] is loaded after the shift.
- Write-back: `wb_valid`/`wb_rd`/`wb_src` are read combinationally from slot[0].
- Pending bitmap `pend[31:0]`:
  - Set on accept of a writing op.
  - Cleared at the edge where slot[0] is valid with that rd.
  - Simultaneous set and clear of the same register: set wins. `pend[0]` is always 0.
- Retiring mask R = one-hot(wb_rd) when `wb_valid`, else 0.
- stall_ID is asserted, for a valid non-flushed op, if any of the following holds:
  - RAW: rsXuse and rsX≠0 and (pend & ~R)[rsX].
  - WAW: writing op and pend[rd] (no R exemption).
  - Port conflict: writing op and slot[L-1] (post-shift, i.e. current slot[L]) is valid.
  - Structural: fu=10 and `div_cnt`≠0.
- `fwd_wb_rsX` = rsXuse & wb_valid & rsX≠0 & wb_rd==rsX. It is independent of stall.
- Divider busy counter `div_cnt`:
  - Loads DIV_LAT-1 on DIV accept.
  - Otherwise decrements while nonzero.
- `mul_start`/`div_start` = accept & fu==01 / fu==10.
- Flush affects only the ID op. Already-accepted ops always complete and write back.

## Timing
- Reset (rst_n low at an edge) clears all RSR slots, `pend`, and `div_cnt`. Consequently the outputs `wb_valid`, `wb_rd`, `wb_src`, `fwd_wb_rs1`, `fwd_wb_rs2` and `stall_ID` are 0. `mul_start` and `div_start` are 0 while rst_n is low.
- Reset mid-operation discards in-flight reservations; no write-back follows.
- For an op accepted at edge n, `wb_valid` is high in the cycle after edge n+L-1, i.e. exactly L cycles after the issue cycle, for one cycle.
- `stall_ID` is purely combinational from current state and ID inputs. A stalled op is re-evaluated every cycle.
- DIV back-to-back: the next DIV can be accepted at edge n+DIV_LAT at the earliest.

## Structure
- Shared package `fu_pkg`:
  - fu codes FU_ALU/FU_MUL/FU_DIV/FU_NONE.
  - RSR slot struct {valid, rd, src}.
  - Default latency constants.
- Sub-module `wb_slot_ring`: parameterised shift register with a load port at index L-1, tap at slot[0], and a read port for slot[L] occupancy.
- Top level holds `pend`, `div_cnt` and the stall/forward logic.

## Test plan
- Reset: hold rst_n=0 for 2 cycles while issue_valid=1 → all outputs 0 and no reservation. After release, an ALU op with rd=5 gives wb_valid, wb_rd=5 three cycles after issue.
- RAW: MUL x7 accepted, then ADD reading x7 → stall_ID for 3 cycles. In the MUL write-back cycle the ADD is accepted with fwd_wb_rs1=1.
- Port conflict: MUL x3 at cycle 0, then ALU x4 at cycle 1 → both target cycle 4, so the ALU stalls 1 cycle, and the writes land at cycle 4 (x3, src=01) and cycle 5 (x4, src=00).
- Structural: DIV x2, then DIV x9 next cycle → div_start once, second DIV stalls 33 cycles and is accepted exactly at cycle 34.
- WAW/x0: MUL x8 then ALU x8 → stall until the MUL retire cycle ends. An ALU op with rd=0 or rs1=0 never stalls and never sets pend.
- Flush: DIV x6 with flush_ID=1 → no div_start, pend[6]=0, and a subsequent op reading x6 does not stall.
